lb_uart_rx_core: RTL
====================

Name: lb_uart_rx_core

Overview:
Parametrised UART receiver. It merges the receive FSM, the oversample tick counter, the bit counter and the shift register into one block. Data width, parity and stop-bit count are configurable. It adds parity and framing checking, false-start rejection, an overrun flag and a valid/read handshake to the local-bus register interface. It sits between the pad-side rx line and the PicoBlaze I/O port decoder; the shared baud generator supplies baud_tick.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB received first
OVERSAMPLE, 16, baud_tick strobes per bit period, even, legal 8..32
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits checked, 1 or 2

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  asynchronous, active-high reset
baud_tick  in  1  one-clk strobe at OVERSAMPLE x baud rate
rx  in  1  serial input, asynchronous to clk, idle high
rd  in  1  one-clk strobe: consumer has read data
data  out  DATA_BITS  last received character
valid  out  1  data holds an unread character
parity_err  out  1  parity mismatch on the character in data
frame_err  out  1  a stop bit sampled low on the character in data
overrun  out  1  a character overwrote unread data
busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset: data=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, state=IDLE, synchroniser flops=1, armed=0. All counters are 0.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s; the raw rx is never used.
- tick_cnt width is $clog2(OVERSAMPLE). It advances only on baud_tick and clears on every state change.
- bit_cnt width is $clog2(DATA_BITS+1).
- armed sets when rx_s=1 is seen in IDLE. A start bit is accepted only when armed=1, so a held-low break line never retriggers reception.
- IDLE: if rx_s=0 and armed=1, go to START and clear armed.
- START: on the baud_tick where tick_cnt reaches OVERSAMPLE/2-1 (mid start bit), sample rx_s. If 0, go to DATA. If 1 (false start), go to IDLE; no flags change.
- DATA: sample every OVERSAMPLE ticks, i.e. at the bit centre. Shift right with MSB-in, so the first bit ends in bit 0. Increment bit_cnt. When bit_cnt reaches DATA_BITS, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: sample once. The computed error is (XOR of data bits XOR sample) != PARITY_ODD.
- STOP: sample STOP_BITS times, one bit period apart. Any sample of 0 records a frame error. The FSM moves from STOP to IDLE on the baud_tick of the final stop-bit sample.
- Commit happens on the clk after the final stop sample. At commit: data is loaded, valid=1, and parity_err and frame_err are loaded. overrun is set to the value valid had before the commit.
- A frame is committed even when it has errors. The FSM does not wait for the stop bit to end, so back-to-back frames with no idle gap are received.
- rd with valid=1: on the next clk, valid, overrun, parity_err and frame_err all become 0. data is held unchanged.
- rd with valid=0: no effect.
- rd and commit in the same cycle: commit wins; valid stays 1 and overrun=0.
- baud_tick is ignored in IDLE. A missing tick stretches the sampling schedule and no other timing is affected.
- reset asserted mid-frame: immediate return to the reset values. The partial frame is discarded.

Decomposition:
- Package lb_uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP) with fixed 3-bit encoding;
  - the parity-mode constants PAR_EVEN=0 and PAR_ODD=1;
  - a function cnt_w(n) returning $clog2(n).
- One sub-module, lb_uart_rx_sync: the 2-flop synchroniser with reset value 1. The counters, shift register and FSM stay in the core.

Test Plan:
- Defaults (8N1, OVERSAMPLE=16), baud_tick every 4 clk, send 0xA5, then pulse rd. Required: data=0xA5, valid=1, all error flags 0. After rd, valid=0.
- 0x5A sent directly after 0x3C with no idle gap and no rd. Required: the first commit gives valid=1 and overrun=0. The second gives data=0x5A, valid=1, overrun=1. After rd, both valid and overrun are 0.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 0. Required: parity_err=1, data=0x07. Repeat with parity bit 1. Required: parity_err=0.
- rx low for only 5 ticks (glitch), then high. Required: busy pulses and returns to IDLE, valid stays 0, no flags set.
- STOP_BITS=2, DATA_BITS=7: send 0x41 with the second stop bit low, then hold rx low for 40 bit times. Required: commit with frame_err=1 and data=0x41. No further commit until rx returns high and a new start bit arrives.
- reset asserted in the middle of data bit 4. Required: all outputs 0 on the reset edge. A following 0xFF frame is received correctly.

Source files
------------

// File: rtl/lb_uart_pkg.sv
// Shared types and helpers for the local-bus UART receiver.
package lb_uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   localparam int PAR_EVEN = 0;
   localparam int PAR_ODD  = 1;

   function automatic int cnt_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/lb_uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pad; resets to the idle-high level.
module lb_uart_rx_sync (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_rx,
   output logic o_rx_s
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_rx;
         r_sync <= r_meta;
      end
   end

   assign o_rx_s = r_sync;

endmodule

// File: rtl/lb_uart_rx_core.sv
// Oversampling UART receiver with parity/framing checks, false-start rejection,
// overrun detection and a valid/rd handshake towards the local bus.
module lb_uart_rx_core
   import lb_uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 baud_tick,
   input  logic                 rx,
   input  logic                 rd,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int TW = cnt_w(OVERSAMPLE);
   localparam int BW = cnt_w(DATA_BITS + 1);

   localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] BIT_TICK  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   localparam logic          ODD_PAR   = (PARITY_ODD == PAR_ODD);
   localparam rx_state_t     AFTER_DATA = (PARITY_EN != 0) ? PARITY : STOP;

   logic                 w_rx_s;
   logic                 w_mid_tick;
   logic                 w_bit_tick;

   rx_state_t            r_state;
   logic [TW-1:0]        r_tick_cnt;
   logic [BW-1:0]        r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_perr;
   logic                 r_ferr;
   logic                 r_armed;
   logic                 r_commit;

   lb_uart_rx_sync u_sync (
      .i_clk   (clk),
      .i_reset (reset),
      .i_rx    (rx),
      .o_rx_s  (w_rx_s)
   );

   assign w_mid_tick = baud_tick && (r_tick_cnt == MID_TICK);
   assign w_bit_tick = baud_tick && (r_tick_cnt == BIT_TICK);
   assign busy       = (r_state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
         r_armed    <= 1'b0;
         r_commit   <= 1'b0;
         data       <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         r_commit <= 1'b0;

         // A read coinciding with a commit consumed the old character, so no overrun.
         if (r_commit) begin
            data       <= r_shift;
            valid      <= 1'b1;
            parity_err <= r_perr;
            frame_err  <= r_ferr;
            overrun    <= valid & ~rd;
         end else if (rd && valid) begin
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (w_rx_s) begin
                  r_armed <= 1'b1;
               end else if (r_armed) begin
                  r_armed    <= 1'b0;
                  r_state    <= START;
                  r_tick_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_perr     <= 1'b0;
                  r_ferr     <= 1'b0;
               end
            end
            START: begin
               if (w_mid_tick) begin
                  r_tick_cnt <= '0;
                  r_state    <= w_rx_s ? IDLE : DATA;
               end else if (baud_tick) begin
                  r_tick_cnt <= r_tick_cnt + TW'(1);
               end
            end
            DATA: begin
               if (w_bit_tick) begin
                  r_tick_cnt <= '0;
                  r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                  if (r_bit_cnt == LAST_DATA) begin
                     r_bit_cnt <= '0;
                     r_state   <= AFTER_DATA;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BW'(1);
                  end
               end else if (baud_tick) begin
                  r_tick_cnt <= r_tick_cnt + TW'(1);
               end
            end
            PARITY: begin
               if (w_bit_tick) begin
                  r_tick_cnt <= '0;
                  r_perr     <= ((^r_shift) ^ w_rx_s) != ODD_PAR;
                  r_state    <= STOP;
               end else if (baud_tick) begin
                  r_tick_cnt <= r_tick_cnt + TW'(1);
               end
            end
            STOP: begin
               // Leave at the last stop-bit centre so a back-to-back start edge is caught.
               if (w_bit_tick) begin
                  r_tick_cnt <= '0;
                  r_ferr     <= r_ferr | ~w_rx_s;
                  if (r_bit_cnt == LAST_STOP) begin
                     r_bit_cnt <= '0;
                     r_state   <= IDLE;
                     r_commit  <= 1'b1;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BW'(1);
                  end
               end else if (baud_tick) begin
                  r_tick_cnt <= r_tick_cnt + TW'(1);
               end
            end
            default: begin
               r_state    <= IDLE;
               r_tick_cnt <= '0;
               r_bit_cnt  <= '0;
            end
         endcase
      end
   end

endmodule
